// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - RV32M funct3 codes, FSM state encoding and operand decode helpers
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_FIX     = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   function automatic logic op_is_div(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic op_is_rem(input logic [2:0] op);
      return op[2] & op[1];
   endfunction

   // MUL keeps only the low half, which is sign-agnostic, so it runs unsigned
   function automatic logic a_is_signed(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic b_is_signed(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step on {remainder, dividend/quotient}
module div_step #(
   parameter int XLEN = 32
) (
   input  logic [2*XLEN-1:0] acc_in,
   input  logic [XLEN-1:0]   divisor,
   output logic [2*XLEN-1:0] acc_out
);

   logic [XLEN:0] rem_shift;
   logic [XLEN:0] diff;

   always_comb begin
      rem_shift = acc_in[2*XLEN-1:XLEN-1];
      diff      = rem_shift - {1'b0, divisor};
      // Partial remainder stays below divisor, so a non-borrow difference fits in XLEN bits
      if (!diff[XLEN]) begin
         acc_out = {diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
      end else begin
         acc_out = {rem_shift[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, UNROLL result bits per compute cycle
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            enable,
   input  logic            flush,
   input  logic            start_valid,
   output logic            start_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1_value,
   input  logic [XLEN-1:0] rs2_value,
   input  logic [4:0]      rd_addr,
   output logic            result_valid,
   input  logic            result_ready,
   output logic [XLEN-1:0] result,
   output logic [4:0]      result_rd,
   output logic            busy
);

   localparam int N  = XLEN / UNROLL;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state, state_next;
   logic [CW-1:0]     cnt;
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] acc_step;
   logic [2*XLEN-1:0] mul_step;
   logic [XLEN:0]     mul_sum;
   logic [XLEN-1:0]   divisor;
   logic [2:0]        op_q;
   logic              neg_q;
   logic              flush_pend;
   logic              armed;
   logic              accept;
   logic              flush_eff;
   logic              special;
   logic [XLEN-1:0]   special_value;
   logic              a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   fix_value;
   logic [2*XLEN-1:0] div_chain [UNROLL+1];

   assign accept    = start_valid && start_ready;
   assign flush_eff = flush || flush_pend;

   // Keeps start_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) armed <= 1'b0;
      else        armed <= 1'b1;
   end

   // A flush seen during a stall is remembered until the next enabled edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      flush_pend <= 1'b0;
      else if (enable) flush_pend <= 1'b0;
      else if (flush)  flush_pend <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      state <= S_IDLE;
      else if (enable) state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (accept) state_next = special ? S_DONE : S_COMPUTE;
         end
         S_COMPUTE: begin
            if (cnt == '0) state_next = S_FIX;
         end
         S_FIX: state_next = S_DONE;
         S_DONE: begin
            if (accept)            state_next = special ? S_DONE : S_COMPUTE;
            else if (result_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      if (flush_eff) state_next = S_IDLE;
   end

   always_comb begin
      start_ready  = armed && enable && !flush && !flush_pend &&
                     ((state == S_IDLE) || ((state == S_DONE) && result_ready));
      result_valid = (state == S_DONE);
      busy         = (state == S_COMPUTE) || (state == S_FIX);
   end

   always_comb begin
      a_neg         = a_is_signed(op) && rs1_value[XLEN-1];
      b_neg         = b_is_signed(op) && rs2_value[XLEN-1];
      a_mag         = a_neg ? -rs1_value : rs1_value;
      b_mag         = b_neg ? -rs2_value : rs2_value;
      special       = 1'b0;
      special_value = '0;
      if (op_is_div(op)) begin
         if (rs2_value == '0) begin
            special       = 1'b1;
            special_value = op_is_rem(op) ? rs1_value : '1;
         end else if (((op == OP_DIV) || (op == OP_REM)) &&
                      (rs1_value == XMIN) && (rs2_value == '1)) begin
            special       = 1'b1;
            special_value = (op == OP_DIV) ? rs1_value : '0;
         end
      end
   end

   // Shift-add multiply: acc = {partial product, remaining multiplier bits}
   always_comb begin
      mul_step = acc;
      mul_sum  = '0;
      for (int i = 0; i < UNROLL; i++) begin
         mul_sum  = {1'b0, mul_step[2*XLEN-1:XLEN]} + (mul_step[0] ? {1'b0, divisor} : '0);
         mul_step = {mul_sum, mul_step[XLEN-1:1]};
      end
   end

   assign div_chain[0] = acc;
   for (genvar g = 0; g < UNROLL; g++) begin : g_div
      div_step #(.XLEN(XLEN)) u_div_step (
         .acc_in  (div_chain[g]),
         .divisor (divisor),
         .acc_out (div_chain[g+1])
      );
   end

   assign acc_step = op_is_div(op_q) ? div_chain[UNROLL] : mul_step;

   always_comb begin
      prod = neg_q ? -acc : acc;
      if (op_is_div(op_q)) begin
         fix_value = op_is_rem(op_q) ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
         if (neg_q) fix_value = -fix_value;
      end else begin
         fix_value = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         acc       <= '0;
         divisor   <= '0;
         op_q      <= OP_MUL;
         neg_q     <= 1'b0;
         result    <= '0;
         result_rd <= '0;
      end else if (enable && !flush_eff) begin
         if (accept) begin
            op_q      <= op;
            result_rd <= rd_addr;
            neg_q     <= op_is_rem(op) ? a_neg : (a_neg ^ b_neg);
            cnt       <= special ? '0 : CW'(N - 1);
            if (special) result <= special_value;
            if (op_is_div(op)) begin
               acc     <= {{XLEN{1'b0}}, a_mag};
               divisor <= b_mag;
            end else begin
               acc     <= {{XLEN{1'b0}}, b_mag};
               divisor <= a_mag;
            end
         end else if (state == S_COMPUTE) begin
            acc <= acc_step;
            if (cnt != '0) cnt <= cnt - CW'(1);
         end else if (state == S_FIX) begin
            result <= fix_value;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed checks of muldiv_unit at UNROLL=1 and UNROLL=4
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b1;
   logic        flush = 1'b0;
   logic        start_valid = 1'b0;
   logic [2:0]  op = OP_MUL;
   logic [31:0] rs1_value = '0;
   logic [31:0] rs2_value = '0;
   logic [4:0]  rd_addr = '0;
   logic        result_ready = 1'b0;

   logic        sr1, rv1, busy1, sr4, rv4, busy4;
   logic [31:0] res1, res4;
   logic [4:0]  rd1, rd4;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(32), .UNROLL(1)) u1 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
      .start_valid(start_valid), .start_ready(sr1), .op(op),
      .rs1_value(rs1_value), .rs2_value(rs2_value), .rd_addr(rd_addr),
      .result_valid(rv1), .result_ready(result_ready), .result(res1),
      .result_rd(rd1), .busy(busy1)
   );

   muldiv_unit #(.XLEN(32), .UNROLL(4)) u4 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
      .start_valid(start_valid), .start_ready(sr4), .op(op),
      .rs1_value(rs1_value), .rs2_value(rs2_value), .rd_addr(rd_addr),
      .result_valid(rv4), .result_ready(result_ready), .result(res4),
      .result_rd(rd4), .busy(busy4)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // lat = enabled edges after the accept edge until result_valid; -1 on timeout
   task automatic issue(input int sel, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, output int lat);
      start_valid = 1'b1;
      op          = o;
      rs1_value   = a;
      rs2_value   = b;
      rd_addr     = rd;
      tick();
      start_valid = 1'b0;
      lat = 0;
      while (!((sel != 0) ? rv4 : rv1) && lat < 200) begin
         tick();
         lat++;
      end
      if (!((sel != 0) ? rv4 : rv1)) lat = -1;
   endtask

   task automatic drain;
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) tick();
      vectors++; if (rv1 !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", rv1); end
      vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy1); end
      vectors++; if (res1 !== 32'h0) begin miscompares++; $display("FAIL reset_result: got %h want 0", res1); end
      vectors++; if (rd1 !== 5'd0) begin miscompares++; $display("FAIL reset_rd: got %h want 0", rd1); end
      vectors++; if (sr1 !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", sr1); end
      rst_n = 1'b1;
      #1;
      vectors++; if (sr1 !== 1'b0) begin miscompares++; $display("FAIL release_ready: got %b want 0", sr1); end
      tick();
      vectors++; if (sr1 !== 1'b1) begin miscompares++; $display("FAIL armed_ready1: got %b want 1", sr1); end
      vectors++; if (sr4 !== 1'b1) begin miscompares++; $display("FAIL armed_ready4: got %b want 1", sr4); end
   endtask

   typedef struct {
      logic [2:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic test_arith;
      vec_t tbl [14];
      int   lat;
      tbl[0]  = '{OP_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33};
      tbl[1]  = '{OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33};
      tbl[2]  = '{OP_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 33};
      tbl[3]  = '{OP_MULHSU, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 33};
      tbl[4]  = '{OP_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33};
      tbl[5]  = '{OP_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33};
      tbl[6]  = '{OP_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 0};
      tbl[7]  = '{OP_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 0};
      tbl[8]  = '{OP_REM,    32'h80000000,   32'hFFFFFFFF, 32'h00000000, 0};
      tbl[9]  = '{OP_REMU,   32'd5,          32'd0,        32'd5,        0};
      tbl[10] = '{OP_DIVU,   32'd100,        32'd7,        32'd14,       33};
      tbl[11] = '{OP_REMU,   32'd100,        32'd7,        32'd2,        33};
      tbl[12] = '{OP_DIV,    32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 33};
      tbl[13] = '{OP_REM,    32'd7,          32'hFFFFFFFE, 32'd1,        33};
      for (int i = 0; i < 14; i++) begin
         issue(0, tbl[i].o, tbl[i].a, tbl[i].b, 5'(i + 1), lat);
         vectors++; if (res1 !== tbl[i].exp) begin miscompares++; $display("FAIL arith%0d_result: got %h want %h", i, res1, tbl[i].exp); end
         vectors++; if (lat != tbl[i].lat) begin miscompares++; $display("FAIL arith%0d_latency: got %0d want %0d", i, lat, tbl[i].lat); end
         vectors++; if (rd1 !== 5'(i + 1)) begin miscompares++; $display("FAIL arith%0d_rd: got %0d want %0d", i, rd1, i + 1); end
         drain();
      end
   endtask

   task automatic test_flush;
      int seen = 0;
      start_valid = 1'b1; op = OP_MUL; rs1_value = 32'd7; rs2_value = 32'hFFFFFFFD; rd_addr = 5'd3;
      tick();
      start_valid = 1'b0;
      repeat (21) tick();
      vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL flush_pre_busy: got %b want 1", busy1); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL flush_busy: got %b want 0", busy1); end
      repeat (40) begin
         if (rv1) seen = 1;
         tick();
      end
      vectors++; if (seen != 0) begin miscompares++; $display("FAIL flush_no_result: got %0d want 0", seen); end
   endtask

   task automatic test_stall;
      int lat;
      start_valid = 1'b1; op = OP_MUL; rs1_value = 32'd7; rs2_value = 32'hFFFFFFFD; rd_addr = 5'd4;
      tick();
      start_valid = 1'b0;
      lat = 0;
      repeat (5) begin tick(); lat++; end
      enable = 1'b0;
      repeat (5) begin tick(); lat++; end
      enable = 1'b1;
      while (!rv1 && lat < 200) begin tick(); lat++; end
      vectors++; if (lat != 38) begin miscompares++; $display("FAIL stall_latency: got %0d want 38", lat); end
      vectors++; if (res1 !== 32'hFFFFFFEB) begin miscompares++; $display("FAIL stall_result: got %h want ffffffeb", res1); end
      drain();
   endtask

   task automatic test_flush_in_stall;
      int seen = 0;
      start_valid = 1'b1; op = OP_DIVU; rs1_value = 32'd50; rs2_value = 32'd3; rd_addr = 5'd6;
      tick();
      start_valid = 1'b0;
      repeat (3) tick();
      enable = 1'b0;
      flush  = 1'b1;
      tick();
      flush = 1'b0;
      repeat (2) tick();
      vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL stall_flush_hold: got %b want 1", busy1); end
      enable = 1'b1;
      tick();
      vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL stall_flush_apply: got %b want 0", busy1); end
      repeat (40) begin
         if (rv1) seen = 1;
         tick();
      end
      vectors++; if (seen != 0) begin miscompares++; $display("FAIL stall_flush_no_result: got %0d want 0", seen); end
   endtask

   task automatic test_reset_midop;
      int seen = 0;
      start_valid = 1'b1; op = OP_MULHU; rs1_value = 32'd9; rs2_value = 32'd9; rd_addr = 5'd7;
      tick();
      start_valid = 1'b0;
      repeat (5) tick();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
      vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL reset_midop_busy: got %b want 0", busy1); end
      repeat (40) begin
         if (rv1) seen = 1;
         tick();
      end
      vectors++; if (seen != 0) begin miscompares++; $display("FAIL reset_midop_no_result: got %0d want 0", seen); end
   endtask

   task automatic test_unroll4;
      int lat;
      issue(1, OP_DIVU, 32'd100, 32'd7, 5'd11, lat);
      vectors++; if (res4 !== 32'd14) begin miscompares++; $display("FAIL u4_divu_result: got %h want 0000000e", res4); end
      vectors++; if (lat != 9) begin miscompares++; $display("FAIL u4_divu_latency: got %0d want 9", lat); end
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++; if (res4 !== 32'd14 || rv4 !== 1'b1 || rd4 !== 5'd11) begin
            miscompares++; $display("FAIL u4_hold%0d: got %h/%b/%0d want 0000000e/1/11", i, res4, rv4, rd4);
         end
      end
      // Back-to-back: new request offered while DONE result is being consumed
      start_valid = 1'b1; op = OP_MUL; rs1_value = 32'd6; rs2_value = 32'd7; rd_addr = 5'd12;
      result_ready = 1'b1;
      #1;
      vectors++; if (sr4 !== 1'b1) begin miscompares++; $display("FAIL u4_b2b_ready: got %b want 1", sr4); end
      tick();
      start_valid = 1'b0;
      result_ready = 1'b0;
      vectors++; if (busy4 !== 1'b1 || rv4 !== 1'b0) begin miscompares++; $display("FAIL u4_b2b_bubble: got busy %b valid %b want 1 0", busy4, rv4); end
      lat = 0;
      while (!rv4 && lat < 200) begin tick(); lat++; end
      vectors++; if (lat != 9) begin miscompares++; $display("FAIL u4_b2b_latency: got %0d want 9", lat); end
      vectors++; if (res4 !== 32'd42 || rd4 !== 5'd12) begin miscompares++; $display("FAIL u4_mul_result: got %h rd %0d want 0000002a rd 12", res4, rd4); end
      drain();
      issue(1, OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd13, lat);
      vectors++; if (res4 !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL u4_div_result: got %h want fffffffd", res4); end
      drain();
   endtask

   initial begin
      test_reset();
      test_arith();
      test_flush();
      test_stall();
      test_flush_in_stall();
      test_reset_midop();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      test_unroll4();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
